// File: rtl/wb_fifo_writer_v2.sv
// wb_fifo_writer_v2 -- Wishbone-to-FIFO write bridge.
//
// Data-port writes push DAT_W-bit words into a FIFO write port. A second 32-bit
// Wishbone port returns a status word and accepts a clear command.
//
// Status word layout:
//   [0]         FIFO full
//   [ADR_W+1:1] FIFO fill level
//   [23]        irq_o (0 when the interrupt is not built)
//   [24]        sticky overflow
//   [31:25]     drop counter, low 7 bits
// Writing 1 to bit 0 of the status port clears the overflow flag and the drop counter.
//
// Build option: define WBFW_IRQ_EN to add the registered irq_o output and status bit 23.
//
// Ports:
//   clk_i, rst_ni                            clock, asynchronous active-low reset
//   wbd_dat_i, wbd_we_i, wbd_cyc_i,
//   wbd_stb_i, wbd_ack_o                     data-port Wishbone slave
//   wbs_dat_i, wbs_we_i, wbs_cyc_i,
//   wbs_stb_i, wbs_ack_o, wbs_dat_o          status-port Wishbone slave
//   wr_dat_o, wr_ena_o, wr_full_i, wr_num_i  FIFO write port
//   irq_o                                    interrupt (WBFW_IRQ_EN only)
module wb_fifo_writer_v2 #(
   parameter int unsigned DAT_W         = 32,
   parameter int unsigned ADR_W         = 4,
   parameter bit          BLOCK_ON_FULL = 1'b1,
   parameter int unsigned IRQ_LVL       = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DAT_W-1:0] wbd_dat_i,
   input  logic             wbd_we_i,
   input  logic             wbd_cyc_i,
   input  logic             wbd_stb_i,
   output logic             wbd_ack_o,
   input  logic [31:0]      wbs_dat_i,
   input  logic             wbs_we_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   output logic [DAT_W-1:0] wr_dat_o,
   output logic             wr_ena_o,
   input  logic             wr_full_i,
   input  logic [ADR_W:0]   wr_num_i
`ifdef WBFW_IRQ_EN
   ,
   output logic             irq_o
`endif
);

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StAckWr,
      StAckRd,
      StAckDrop
   } state_e;

   state_e     state_q, state_d;
   logic       wbs_ack_q, wbs_ack_d;
   logic       ovf_q, ovf_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   logic       data_req;
   logic       stat_req;
   logic       stat_clr;
   logic       drop;
   logic [7:0] cnt_base;
   logic [31:0] stat;

   assign data_req = wbd_cyc_i & wbd_stb_i;
   assign stat_req = wbs_cyc_i & wbs_stb_i;

   // Data-port FSM.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (data_req) begin
               if (!wbd_we_i)          state_d = StAckRd;
               else if (!wr_full_i)    state_d = StAckWr;
               else if (BLOCK_ON_FULL) state_d = StWait;
               else                    state_d = StAckDrop;
            end
         end
         StWait: begin
            // Master abandoning the cycle while we stall: no push, no ack.
            if (!data_req)       state_d = StIdle;
            else if (!wr_full_i) state_d = StAckWr;
         end
         StAckWr, StAckRd, StAckDrop: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign wbd_ack_o = (state_q == StAckWr) | (state_q == StAckRd) | (state_q == StAckDrop);
   assign wr_ena_o  = (state_q == StAckWr);
   assign wr_dat_o  = wbd_dat_i;

   // Status ack: one-cycle pulse, then held low for a cycle before the next one.
   assign wbs_ack_d = stat_req & ~wbs_ack_q;
   assign wbs_ack_o = wbs_ack_q;

   // Clear and drop in the same cycle: the clear lands first, then the drop counts.
   assign stat_clr = wbs_ack_q & stat_req & wbs_we_i & wbs_dat_i[0];
   assign drop     = (state_q == StAckDrop);

   always_comb begin
      cnt_base   = stat_clr ? 8'd0 : drop_cnt_q;
      drop_cnt_d = cnt_base;
      if (drop && (cnt_base != 8'hFF)) drop_cnt_d = cnt_base + 8'd1;
      ovf_d = (ovf_q & ~stat_clr) | drop;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         wbs_ack_q  <= 1'b0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wbs_ack_q  <= wbs_ack_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

`ifdef WBFW_IRQ_EN
   localparam int FifoCap = 1 << ADR_W;

   logic irq_q, irq_d;

   // Free space compared as signed so an over-range fill level cannot wrap.
   assign irq_d = ovf_q | ((FifoCap - int'(wr_num_i)) > int'(IRQ_LVL));
   assign irq_o = irq_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end
`else
   logic unused_irq_lvl;
   assign unused_irq_lvl = ^IRQ_LVL;
`endif

   always_comb begin
      stat              = '0;
      stat[0]           = wr_full_i;
      stat[ADR_W+1:1]   = wr_num_i;
      stat[24]          = ovf_q;
      stat[31:25]       = drop_cnt_q[6:0];
`ifdef WBFW_IRQ_EN
      stat[23]          = irq_q;
`endif
   end

   assign wbs_dat_o = stat;

   logic unused_wbs_dat;
   assign unused_wbs_dat = ^wbs_dat_i[31:1];

endmodule

// File: tb/tb_wb_fifo_writer_v2.sv
// Bench for wb_fifo_writer_v2: instance 0 stalls on full, instance 1 drops on full.
// Pushes are predicted into a queue when a write is driven and matched as they appear.
module tb_wb_fifo_writer_v2;

   localparam int AdrW   = 4;
   localparam int IrqLvl = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] d_dat [2];
   logic        d_we [2], d_cyc [2], d_stb [2], d_ack [2];
   logic [31:0] s_dat_i [2], s_dat_o [2];
   logic        s_we [2], s_cyc [2], s_stb [2], s_ack [2];
   logic [31:0] wdat [2];
   logic        wena [2], full [2];
   logic [4:0]  num [2];
`ifdef WBFW_IRQ_EN
   logic        irq [2];
`endif

   int n_checks = 0;
   int n_err    = 0;
   int n_ack [2];
   int n_push [2];
   logic [31:0] exp_q0[$];

   // bench-side status model state for instance 1
   int m_cnt = 0;
   bit m_ovf = 0;

   wb_fifo_writer_v2 #(
      .DAT_W(32), .ADR_W(AdrW), .BLOCK_ON_FULL(1'b1), .IRQ_LVL(IrqLvl)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .wbd_dat_i(d_dat[0]), .wbd_we_i(d_we[0]), .wbd_cyc_i(d_cyc[0]), .wbd_stb_i(d_stb[0]),
      .wbd_ack_o(d_ack[0]),
      .wbs_dat_i(s_dat_i[0]), .wbs_we_i(s_we[0]), .wbs_cyc_i(s_cyc[0]), .wbs_stb_i(s_stb[0]),
      .wbs_ack_o(s_ack[0]), .wbs_dat_o(s_dat_o[0]),
      .wr_dat_o(wdat[0]), .wr_ena_o(wena[0]), .wr_full_i(full[0]), .wr_num_i(num[0])
`ifdef WBFW_IRQ_EN
      , .irq_o(irq[0])
`endif
   );

   wb_fifo_writer_v2 #(
      .DAT_W(32), .ADR_W(AdrW), .BLOCK_ON_FULL(1'b0), .IRQ_LVL(IrqLvl)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .wbd_dat_i(d_dat[1]), .wbd_we_i(d_we[1]), .wbd_cyc_i(d_cyc[1]), .wbd_stb_i(d_stb[1]),
      .wbd_ack_o(d_ack[1]),
      .wbs_dat_i(s_dat_i[1]), .wbs_we_i(s_we[1]), .wbs_cyc_i(s_cyc[1]), .wbs_stb_i(s_stb[1]),
      .wbs_ack_o(s_ack[1]), .wbs_dat_o(s_dat_o[1]),
      .wr_dat_o(wdat[1]), .wr_ena_o(wena[1]), .wr_full_i(full[1]), .wr_num_i(num[1])
`ifdef WBFW_IRQ_EN
      , .irq_o(irq[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic bit irq_model(bit ovf, logic [4:0] nm);
      return ovf || ((16 - int'(nm)) > IrqLvl);
   endfunction

   function automatic logic [31:0] stat_model(bit f, logic [4:0] nm, bit ovf, int cnt);
      logic [31:0] s;
      logic [7:0]  c;
      c        = cnt[7:0];
      s        = '0;
      s[0]     = f;
      s[5:1]   = nm;
      s[24]    = ovf;
      s[31:25] = c[6:0];
`ifdef WBFW_IRQ_EN
      s[23]    = irq_model(ovf, nm);
`endif
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Data-port access; holds the cycle through the ack cycle like a real master.
   task automatic wb_xfer(input int k, input bit we, input logic [31:0] d, input bit exp_push,
                          input int budget, output int lat);
      if (k == 0 && exp_push) exp_q0.push_back(d);
      d_dat[k] = d; d_we[k] = we; d_cyc[k] = 1'b1; d_stb[k] = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!d_ack[k] && lat < budget);
      check_eq("wbd_ack_seen", 64'(d_ack[k]), 64'd1);
      if (d_ack[k] && we) check_eq("wr_dat", 64'(wdat[k]), 64'(d));
      tick();
      d_cyc[k] = 1'b0; d_stb[k] = 1'b0; d_we[k] = 1'b0;
   endtask

   task automatic wbs_xfer(input int k, input bit we, input logic [31:0] d,
                           output logic [31:0] rd);
      int lat;
      s_dat_i[k] = d; s_we[k] = we; s_cyc[k] = 1'b1; s_stb[k] = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!s_ack[k] && lat < 5);
      check_eq("wbs_lat", 64'(lat), 64'd1);
      rd = s_dat_o[k];
      tick();
      s_cyc[k] = 1'b0; s_stb[k] = 1'b0; s_we[k] = 1'b0;
   endtask

   // Scoreboard / monitor, sampled on the falling edge.
   initial begin
      n_ack[0] = 0; n_ack[1] = 0; n_push[0] = 0; n_push[1] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (d_ack[k]) n_ack[k]++;
            if (wena[k]) n_push[k]++;
         end
         if (wena[0]) begin
            if (exp_q0.size() != 0) check_eq("push_dat0", 64'(wdat[0]), 64'(exp_q0.pop_front()));
            else check_eq("push_unexp0", 64'(wena[0]), 64'd0);
         end
         if (wena[1]) check_eq("push_unexp1", 64'(wena[1]), 64'd0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p0, a0;
      logic [31:0] rd;
      logic [3:0] seq;
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         d_dat[k] = '0; d_we[k] = 0; d_cyc[k] = 0; d_stb[k] = 0;
         s_dat_i[k] = '0; s_we[k] = 0; s_cyc[k] = 0; s_stb[k] = 0;
         full[k] = 0; num[k] = '0;
      end
      #22;
      check_eq("rst_ack", 64'({d_ack[0], d_ack[1], s_ack[0], s_ack[1]}), 64'd0);
      check_eq("rst_ena", 64'({wena[0], wena[1]}), 64'd0);
      check_eq("rst_cnt", 64'({dut1.ovf_q, dut1.drop_cnt_q}), 64'd0);
`ifdef WBFW_IRQ_EN
      check_eq("rst_irq", 64'({irq[0], irq[1]}), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Plain write, FIFO empty
      p0 = n_push[0];
      wb_xfer(0, 1'b1, 32'hA5A5_0001, 1'b1, 10, lat);
      check_eq("wr_lat", 64'(lat), 64'd1);
      check_eq("wr_ena_after", 64'(wena[0]), 64'd0);
      tick();
      check_eq("wr_push_cnt", 64'(n_push[0] - p0), 64'd1);
      wbs_xfer(0, 1'b0, 32'h0, rd);
      check_eq("stat_empty", 64'(rd), 64'(stat_model(1'b0, 5'd0, 1'b0, 0)));

      // Back-to-back writes: one word every two cycles
      for (int i = 0; i < 4; i++) begin
         wb_xfer(0, 1'b1, 32'h1000_0000 + 32'(i * 7), 1'b1, 10, lat);
         check_eq("b2b_lat", 64'(lat), 64'd1);
      end

      // Stall while full for 5 cycles
      p0 = n_push[0];
      full[0] = 1'b1;
      fork
         wb_xfer(0, 1'b1, 32'hBEEF_0002, 1'b1, 30, lat);
         begin
            repeat (5) tick();
            full[0] = 1'b0;
         end
      join
      check_eq("stall_lat", 64'(lat), 64'd6);
      tick();
      check_eq("stall_push_cnt", 64'(n_push[0] - p0), 64'd1);

      // Abort while stalled
      p0 = n_push[0]; a0 = n_ack[0];
      full[0] = 1'b1;
      d_dat[0] = 32'hDEAD_0003; d_we[0] = 1; d_cyc[0] = 1; d_stb[0] = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("abort_noack", 64'(d_ack[0]), 64'd0);
      end
      d_cyc[0] = 0; d_stb[0] = 0; d_we[0] = 0;
      tick();
      check_eq("abort_idle", 64'(dut0.state_q), 64'd0);
      tick();
      check_eq("abort_acks", 64'(n_ack[0] - a0), 64'd0);
      check_eq("abort_push", 64'(n_push[0] - p0), 64'd0);
      full[0] = 1'b0;

      // Status ack pulse pattern with the request held
      s_cyc[0] = 1; s_stb[0] = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         seq[3-i] = s_ack[0];
      end
      check_eq("stat_ack_seq", 64'(seq), 64'hA);
      s_cyc[0] = 0; s_stb[0] = 0;
      tick();

      // Drop mode: 300 writes into a full FIFO
      full[1] = 1'b1;
      a0 = n_ack[1];
      for (int i = 0; i < 300; i++) begin
         wb_xfer(1, 1'b1, 32'(i), 1'b0, 10, lat);
         check_eq("drop_lat", 64'(lat), 64'd1);
         m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         m_ovf = 1'b1;
      end
      tick();
      check_eq("drop_acks", 64'(n_ack[1] - a0), 64'd300);
      check_eq("drop_push", 64'(n_push[1]), 64'd0);
      check_eq("drop_cnt_int", 64'(dut1.drop_cnt_q), 64'(m_cnt));
      wbs_xfer(1, 1'b0, 32'h0, rd);
      check_eq("stat_sat", 64'(rd), 64'(stat_model(1'b1, 5'd0, m_ovf, m_cnt)));
      wbs_xfer(1, 1'b1, 32'h1, rd);
      m_cnt = 0; m_ovf = 1'b0;
      wbs_xfer(1, 1'b0, 32'h0, rd);
      check_eq("stat_clr", 64'(rd), 64'(stat_model(1'b1, 5'd0, m_ovf, m_cnt)));

      // Clear coinciding with a drop
      for (int i = 0; i < 2; i++) begin
         wb_xfer(1, 1'b1, 32'h55, 1'b0, 10, lat);
         m_cnt++; m_ovf = 1'b1;
      end
      fork
         wb_xfer(1, 1'b1, 32'h66, 1'b0, 10, lat);
         wbs_xfer(1, 1'b1, 32'h1, rd);
      join
      m_cnt = 1; m_ovf = 1'b1;
      check_eq("coinc_cnt", 64'(dut1.drop_cnt_q), 64'(m_cnt));
      check_eq("coinc_ovf", 64'(dut1.ovf_q), 64'(m_ovf));
      wb_xfer(1, 1'b0, 32'h0, 1'b0, 10, lat);
      check_eq("rd_lat", 64'(lat), 64'd1);
      wbs_xfer(1, 1'b0, 32'h0, rd);
      check_eq("stat_coinc", 64'(rd), 64'(stat_model(1'b1, 5'd0, m_ovf, m_cnt)));
      full[1] = 1'b0;

`ifdef WBFW_IRQ_EN
      for (int i = 0; i < 4; i++) begin
         num[0] = 5'(10 + i);
         tick();
         check_eq("irq_lvl", 64'(irq[0]), 64'(irq_model(1'b0, num[0])));
         check_eq("irq_stat23", 64'(s_dat_o[0][23]), 64'(irq_model(1'b0, num[0])));
      end
      num[0] = '0;
      tick();
`endif

      // Reset asserted while an ack/push and a status ack are pending
      d_dat[0] = 32'h7777_0004; d_we[0] = 1; d_cyc[0] = 1; d_stb[0] = 1;
      s_cyc[0] = 1; s_stb[0] = 1;
      tick();
      check_eq("pre_rst_ack", 64'({d_ack[0], wena[0], s_ack[0]}), 64'h7);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_outs", 64'({d_ack[0], wena[0], s_ack[0]}), 64'd0);
      check_eq("arst_cnt", 64'({dut1.ovf_q, dut1.drop_cnt_q}), 64'd0);
      check_eq("arst_state", 64'(dut0.state_q), 64'd0);
`ifdef WBFW_IRQ_EN
      check_eq("arst_irq", 64'({irq[0], irq[1]}), 64'd0);
`endif
      d_cyc[0] = 0; d_stb[0] = 0; d_we[0] = 0; s_cyc[0] = 0; s_stb[0] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      check_eq("q_empty", 64'(exp_q0.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_fifo_writer_v2.md
# wb_fifo_writer_v2

Parametrised Wishbone-to-FIFO write bridge for the SD controller bench and data path: data-port writes push DAT_W-bit words into a FIFO write port. A 32-bit status/control port exposes fill level, full, sticky overflow and a drop counter. When the FIFO is full, a write either stalls (wait states) or is acknowledged and dropped, selected by parameter.

## Interface
- DAT_W, 32: data word width, 8..64.
- ADR_W, 4: FIFO address width; `wr_num_i` is ADR_W+1 bits wide; legal range 1..20.
- BLOCK_ON_FULL, 1: 1 stalls the ack while the FIFO is full; 0 acks and drops the word.
- IRQ_LVL, 0: free-level threshold, used only with `WBFW_IRQ_EN`.
- clk_i  in  1  clock, all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- wbd_dat_i  in  DAT_W  write data; master holds it stable until ack.
- wbd_we_i, wbd_cyc_i, wbd_stb_i  in  1 each  data-port cycle controls.
- wbd_ack_o  out  1  data-port ack.
- wbs_dat_i  in  32  status-port write data.
- wbs_we_i, wbs_cyc_i, wbs_stb_i  in  1 each  status-port cycle controls.
- wbs_ack_o  out  1  status-port ack.
- wbs_dat_o  out  32  status word.
- wr_dat_o  out  DAT_W  FIFO write data.
- wr_ena_o  out  1  FIFO push strobe.
- wr_full_i  in  1  FIFO full.
- wr_num_i  in  ADR_W+1  FIFO fill level (words).
- irq_o  out  1  interrupt; present only with `WBFW_IRQ_EN`.

## Operation
- Data FSM states: IDLE, WAIT, ACK_WR, ACK_RD, ACK_DROP.
- In IDLE, on `cyc&stb`:
  - `!we` goes to ACK_RD.
  - `we & !wr_full_i` goes to ACK_WR.
  - `we & full` goes to WAIT when BLOCK_ON_FULL=1, else to ACK_DROP.
- WAIT:
  - `!cyc | !stb` returns to IDLE with no push and no ack (abort).
  - Otherwise `!wr_full_i` goes to ACK_WR; it stays in WAIT while full.
- ACK_WR, ACK_RD and ACK_DROP each return to IDLE after one cycle.
- Output decodes:
  - `wbd_ack_o` = state is ACK_WR, ACK_RD or ACK_DROP.
  - `wr_ena_o` = state is ACK_WR.
  - `wr_dat_o` = `wbd_dat_i`, combinational.
- ACK_DROP sets sticky `ovf_q` and increments the 8-bit `drop_cnt`, which saturates at 255.
- Status word on `wbs_dat_o`:
  - bit 0 = `wr_full_i`.
  - bits ADR_W+1..1 = `wr_num_i`.
  - bit 24 = `ovf_q`.
  - bits 31..25 = `drop_cnt[6:0]`.
  - All other bits are 0.
  - `drop_cnt[7]` is not visible; a value of 128 or more reads as the low 7 bits.
- Status write is applied on the ack cycle. `wbs_dat_i[0]=1` clears `ovf_q` and `drop_cnt`. Other bits are ignored.
- If a clear and a drop occur in the same cycle, the result is `drop_cnt`=1 and `ovf_q`=1.

## Timing
- Reset values: state IDLE; `wbd_ack_o`, `wr_ena_o`, `wbs_ack_o`, `ovf_q`, `drop_cnt` and `irq_o` all 0.
- Reset is asynchronous: assertion mid-transfer kills any pending ack or push immediately.
- Data write latency, not full: request seen in cycle N; ack and push in cycle N+1; idle in N+2.
  - Back-to-back writes therefore run at most one word every 2 cycles.
- `wr_full_i` is sampled only in IDLE and WAIT. Only this block pushes, so full cannot assert between the sample and the push.
- Blocking mode: ack and push occur in the cycle after `wr_full_i` is first seen low in WAIT.
- Status ack: a one-cycle pulse one cycle after `cyc&stb`, then forced low for one cycle, so the port sustains at most one access every 2 cycles.
- `wbs_dat_o` is combinational from the live inputs and registers.
- The data port and status port operate fully concurrently.

## Configuration
- `WBFW_IRQ_EN` defined:
  - Adds `irq_o`, registered, equal to `ovf_q | (2**ADR_W - wr_num_i > IRQ_LVL)`.
  - Updates one cycle after its inputs change.
  - Adds read-only bit 23 of the status word, reflecting `irq_o`.
- `WBFW_IRQ_EN` undefined: no `irq_o` port, bit 23 reads 0, and IRQ_LVL is ignored.

## Test plan
- Reset, then write 0xA5A5_0001 with FIFO empty: ack in cycle N+1, `wr_ena_o` for exactly 1 cycle, `wr_dat_o`=0xA5A5_0001; status reads 0.
- BLOCK_ON_FULL=1, `wr_full_i`=1 for 5 cycles, then 0: no ack for 5 cycles; ack and push exactly once, one cycle after full drops.
- BLOCK_ON_FULL=1, full held, master drops `cyc` after 3 cycles: no ack, no push, FSM back in IDLE.
- BLOCK_ON_FULL=0, full held, 300 writes: 300 acks and 0 pushes; internal `drop_cnt`=255; status bit 24 = 1 and bits 31..25 = 0x7F. Status write of 0x1: status reads 0 in those fields.
- Data-port read while status write clear coincides with a drop: data ack after 1 cycle; `drop_cnt`=1 and `ovf_q`=1 afterwards.
- With `WBFW_IRQ_EN`, ADR_W=4, IRQ_LVL=4, `wr_num_i` stepped 10, 11, 12, 13: `irq_o` = 1, 1, 0, 0, each one cycle after the change.
- Mid-wait reset assertion: all outputs 0 asynchronously.
